mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//   Shares the single data-memory port between the Pipelined_Processor data-memory interface (CPU) and a
//   DMA/test-loader port used to preload and dump memory. Sequences each access over a fixed memory latency.
//   Stalls the CPU while it waits, and alternates the port round-robin when both sides are requesting.
// PARAMETERS
//   DataWidth   16  data bus width
//   AddrWidth   16  address bus width
//   MemLatency  2   cycles a command is held on the memory port; must be >= 1
// PORTS
//   CLK           in   1          system clock, rising edge
//   RST           in   1          asynchronous reset, active-low
//   CpuMemRead    in   1          CPU load request (level)
//   CpuMemWrite   in   1          CPU store request (level); wins over CpuMemRead if both are high
//   CpuMemAddr    in   AddrWidth  CPU address
//   CpuMemData    in   DataWidth  CPU store data
//   CpuMemOutput  out  DataWidth  CPU load data, registered
//   CpuStall      out  1          freeze the CPU pipeline
//   DmaReq        in   1          DMA request (level, held until DmaAck)
//   DmaWe         in   1          1 = write, 0 = read
//   DmaAddr       in   AddrWidth  DMA address
//   DmaWData      in   DataWidth  DMA write data
//   DmaRData      out  DataWidth  DMA read data, registered
//   DmaAck        out  1          one-cycle completion pulse
//   MemRead       out  1          memory read strobe
//   MemWrite      out  1          memory write strobe
//   MemAddr       out  AddrWidth  memory address
//   MemData       out  DataWidth  memory write data
//   MemOutput     in   DataWidth  memory read data
// BEHAVIOUR
//   - Reset (RST=0, asynchronous):
//     - state=IDLE, beat counter=0, LastGrant=DMA.
//     - All outputs 0.
//     - Any in-flight transfer is aborted with no Ack or done pulse.
//   - States: IDLE, CPU_ACC, DMA_ACC.
//   - Memory-port outputs are registered and latched at the grant edge.
//     - They hold stable for exactly MemLatency cycles.
//     - They are all 0 in IDLE.
//   - CPU candidate: (CpuMemRead | CpuMemWrite) while cpu_done is low.
//     - cpu_done is a registered pulse, high for the one cycle after the CPU's last beat.
//   - DMA candidate: DmaReq while DmaAck is low.
//   - IDLE: the grant is decided at the rising edge.
//     - Single candidate -> grant it.
//     - Both candidates -> grant the side that is not LastGrant; LastGrant is updated on every grant.
//     - No candidate -> remain in IDLE.
//   - CPU_ACC / DMA_ACC: the beat counter runs 0..MemLatency-1.
//     - On the last beat the state returns to IDLE.
//     - On a read, MemOutput is captured into CpuMemOutput or DmaRData.
//     - cpu_done (CPU) or DmaAck (DMA) goes high for the next cycle.
//   - Read data registers hold their value until the next read by the same side; writes leave them unchanged.
//   - CpuStall = CPU request asserted && !cpu_done (combinational).
//     - For a request first seen in cycle N: stall spans N..N+MemLatency, and the pipeline advances in N+MemLatency+1.
//   - Arbitration also occurs in the done/Ack cycle, so there is no idle gap between alternating grants.
//   - Requests deasserted mid-transfer do not abort; the transfer completes and its done/Ack still fires.
//   - CPU address/data changes mid-transfer are ignored (latched at grant); the same holds for the DMA side.
//   - DMA must keep DmaReq high until DmaAck; DmaReq still high in the cycle after Ack is a new request.
// TESTING
//   1. Reset: hold RST=0, toggle CLK -> all outputs 0; release RST -> IDLE, no memory strobes.
//   2. CPU read, addr 0x0010, MemOutput=0x1234, MemLatency=2:
//      - MemRead high and MemAddr=0x0010 for 2 cycles.
//      - CpuStall high for 3 cycles.
//      - CpuMemOutput=0x1234 when the stall drops.
//   3. DMA write 0xBEEF to 0x0040:
//      - MemWrite high 2 cycles with MemAddr=0x0040, MemData=0xBEEF.
//      - DmaAck pulses exactly once, 3 cycles after DmaReq rises.
//   4. CPU read and DmaReq in the same cycle after reset:
//      - CPU is granted first (accesses in cycles 1-2).
//      - DMA is granted in the CPU done cycle (accesses in cycles 4-5); DmaAck in cycle 6.
//   5. CPU and DMA both requesting continuously for 6 transfers -> grants alternate CPU, DMA, CPU, DMA...; neither side waits more than one transfer.
//   6. RST=0 during the second beat of a DMA read:
//      - Strobes clear immediately; no DmaAck.
//      - After release with DmaReq still high, the transfer restarts from beat 0.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one data-memory port between the CPU data-memory interface and a DMA/test-loader
//   port. Each granted access holds its command on the memory port for MemLatency cycles.
//   The CPU is stalled while it waits. When both sides request, the grant alternates.
//
// Ports
//   CLK, RST        clock (rising edge), asynchronous active-low reset
//   CpuMemRead/Write CPU load/store request levels (write wins); CpuMemAddr/CpuMemData command
//   CpuMemOutput    registered CPU load data
//   CpuStall        freezes the CPU pipeline while its access is pending or in flight
//   DmaReq/DmaWe    DMA request level and direction; DmaAddr/DmaWData command
//   DmaRData        registered DMA read data; DmaAck one-cycle completion pulse
//   MemRead/MemWrite/MemAddr/MemData  registered memory command; MemOutput memory read data
module mem_port_arbiter #(
    parameter int unsigned DataWidth  = 16,
    parameter int unsigned AddrWidth  = 16,
    parameter int unsigned MemLatency = 2
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 CpuMemRead,
    input  logic                 CpuMemWrite,
    input  logic [AddrWidth-1:0] CpuMemAddr,
    input  logic [DataWidth-1:0] CpuMemData,
    output logic [DataWidth-1:0] CpuMemOutput,
    output logic                 CpuStall,
    input  logic                 DmaReq,
    input  logic                 DmaWe,
    input  logic [AddrWidth-1:0] DmaAddr,
    input  logic [DataWidth-1:0] DmaWData,
    output logic [DataWidth-1:0] DmaRData,
    output logic                 DmaAck,
    output logic                 MemRead,
    output logic                 MemWrite,
    output logic [AddrWidth-1:0] MemAddr,
    output logic [DataWidth-1:0] MemData,
    input  logic [DataWidth-1:0] MemOutput
);

    localparam int unsigned BeatWidth = (MemLatency > 1) ? $clog2(MemLatency) : 1;
    localparam logic [BeatWidth-1:0] LastBeat = BeatWidth'(MemLatency - 1);

    typedef enum logic [1:0] {
        StIdle,
        StCpuAcc,
        StDmaAcc
    } state_e;

    state_e                 state_q;
    logic [BeatWidth-1:0]   beat_q;
    logic                   last_grant_dma_q;  // 1: the most recent grant went to the DMA side
    logic                   cpu_done_q;
    logic                   dma_ack_q;
    logic                   mem_read_q;
    logic                   mem_write_q;
    logic [AddrWidth-1:0]   mem_addr_q;
    logic [DataWidth-1:0]   mem_data_q;
    logic [DataWidth-1:0]   cpu_rdata_q;
    logic [DataWidth-1:0]   dma_rdata_q;

    logic cpu_req;
    logic cpu_cand;
    logic dma_cand;
    logic grant_cpu;
    logic grant_dma;

    assign cpu_req = CpuMemRead | CpuMemWrite;

    // The done/Ack pulse masks the requester for one cycle so a held level is not re-granted.
    always_comb begin
        cpu_cand  = cpu_req & ~cpu_done_q;
        dma_cand  = DmaReq & ~dma_ack_q;
        grant_cpu = 1'b0;
        grant_dma = 1'b0;
        if (state_q == StIdle) begin
            if (cpu_cand && dma_cand) begin
                grant_cpu = last_grant_dma_q;
                grant_dma = ~last_grant_dma_q;
            end else begin
                grant_cpu = cpu_cand;
                grant_dma = dma_cand;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q          <= StIdle;
            beat_q           <= '0;
            last_grant_dma_q <= 1'b1;
            cpu_done_q       <= 1'b0;
            dma_ack_q        <= 1'b0;
            mem_read_q       <= 1'b0;
            mem_write_q      <= 1'b0;
            mem_addr_q       <= '0;
            mem_data_q       <= '0;
            cpu_rdata_q      <= '0;
            dma_rdata_q      <= '0;
        end else begin
            cpu_done_q <= 1'b0;
            dma_ack_q  <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    beat_q <= '0;
                    if (grant_cpu) begin
                        state_q          <= StCpuAcc;
                        last_grant_dma_q <= 1'b0;
                        mem_write_q      <= CpuMemWrite;
                        mem_read_q       <= ~CpuMemWrite;
                        mem_addr_q       <= CpuMemAddr;
                        mem_data_q       <= CpuMemWrite ? CpuMemData : '0;
                    end else if (grant_dma) begin
                        state_q          <= StDmaAcc;
                        last_grant_dma_q <= 1'b1;
                        mem_write_q      <= DmaWe;
                        mem_read_q       <= ~DmaWe;
                        mem_addr_q       <= DmaAddr;
                        mem_data_q       <= DmaWe ? DmaWData : '0;
                    end
                end
                StCpuAcc, StDmaAcc: begin
                    if (beat_q == LastBeat) begin
                        // Last beat: capture read data, drop the command, pulse completion.
                        state_q     <= StIdle;
                        beat_q      <= '0;
                        mem_read_q  <= 1'b0;
                        mem_write_q <= 1'b0;
                        mem_addr_q  <= '0;
                        mem_data_q  <= '0;
                        if (state_q == StCpuAcc) begin
                            cpu_done_q <= 1'b1;
                            if (mem_read_q) cpu_rdata_q <= MemOutput;
                        end else begin
                            dma_ack_q <= 1'b1;
                            if (mem_read_q) dma_rdata_q <= MemOutput;
                        end
                    end else begin
                        beat_q <= beat_q + BeatWidth'(1);
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Stall is combinational so the pipeline freezes in the same cycle the request appears;
    // gated by reset so every output reads 0 while reset is held.
    assign CpuStall     = RST & cpu_req & ~cpu_done_q;
    assign CpuMemOutput = cpu_rdata_q;
    assign DmaRData     = dma_rdata_q;
    assign DmaAck       = dma_ack_q;
    assign MemRead      = mem_read_q;
    assign MemWrite     = mem_write_q;
    assign MemAddr      = mem_addr_q;
    assign MemData      = mem_data_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

    localparam int L = 2;

    logic        CLK = 1'b0;
    logic        RST;
    logic        CpuMemRead, CpuMemWrite;
    logic [15:0] CpuMemAddr, CpuMemData, CpuMemOutput;
    logic        CpuStall;
    logic        DmaReq, DmaWe;
    logic [15:0] DmaAddr, DmaWData, DmaRData;
    logic        DmaAck;
    logic        MemRead, MemWrite;
    logic [15:0] MemAddr, MemData, MemOutput;

    always #5 CLK = ~CLK;

    mem_port_arbiter #(
        .DataWidth (16),
        .AddrWidth (16),
        .MemLatency(L)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .CpuMemRead  (CpuMemRead),
        .CpuMemWrite (CpuMemWrite),
        .CpuMemAddr  (CpuMemAddr),
        .CpuMemData  (CpuMemData),
        .CpuMemOutput(CpuMemOutput),
        .CpuStall    (CpuStall),
        .DmaReq      (DmaReq),
        .DmaWe       (DmaWe),
        .DmaAddr     (DmaAddr),
        .DmaWData    (DmaWData),
        .DmaRData    (DmaRData),
        .DmaAck      (DmaAck),
        .MemRead     (MemRead),
        .MemWrite    (MemWrite),
        .MemAddr     (MemAddr),
        .MemData     (MemData),
        .MemOutput   (MemOutput)
    );

    // ---------------- counters / cycle index ----------------
    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- memory model ----------------
    // Unwritten words read back a fixed address-derived pattern; word 0x10 reads 0x1234.
    function automatic logic [15:0] init_val(input logic [7:0] a);
        logic [15:0] d;
        d = {8'h00, a} - 16'h0010;
        return 16'h1234 ^ 16'(d * 16'h9E37);
    endfunction

    logic [15:0] mem_arr [256];
    bit          mem_wr  [256];
    always @(posedge CLK) begin
        if (MemWrite) begin
            mem_arr[MemAddr[7:0]] <= MemData;
            mem_wr[MemAddr[7:0]]  <= 1'b1;
        end
    end
    assign MemOutput = !MemRead ? 16'hDEAD :
                       (mem_wr[MemAddr[7:0]] ? mem_arr[MemAddr[7:0]] : init_val(MemAddr[7:0]));

    // ---------------- reference model (transaction schedule by cycle number) ----------------
    typedef struct {
        bit          cpu;
        bit          we;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] rdata;
        int          start;
    } txn_t;

    txn_t        sb[$];
    bit          grant_log[$];
    logic [15:0] refmem [256];
    int          busy_until   = -10;
    int          cpu_done_cyc = -10;
    int          dma_ack_cyc  = -10;
    bit          last_dma     = 1'b1;
    bit          exp_stall    = 1'b0;
    bit          exp_ack      = 1'b0;

    initial begin : model
        txn_t t;
        bit   cc, dc, pick_cpu;
        for (int i = 0; i < 256; i++) refmem[i] = init_val(8'(i));
        forever begin
            @(posedge CLK);
            #2;
            if (!RST) begin
                busy_until   = -10;
                cpu_done_cyc = -10;
                dma_ack_cyc  = -10;
                last_dma     = 1'b1;
                exp_stall    = 1'b0;
                exp_ack      = 1'b0;
                sb.delete();
            end else begin
                cc        = (CpuMemRead || CpuMemWrite) && (cyc != cpu_done_cyc);
                dc        = DmaReq && (cyc != dma_ack_cyc);
                exp_stall = cc;
                exp_ack   = (cyc == dma_ack_cyc);
                if (cyc > busy_until && (cc || dc)) begin
                    pick_cpu = cc && (!dc || last_dma);
                    t.cpu    = pick_cpu;
                    t.we     = pick_cpu ? CpuMemWrite : DmaWe;
                    t.addr   = pick_cpu ? CpuMemAddr : DmaAddr;
                    t.wdata  = pick_cpu ? CpuMemData : DmaWData;
                    t.start  = cyc + 1;
                    t.rdata  = 16'h0;
                    if (t.we) refmem[t.addr[7:0]] = t.wdata;
                    else      t.rdata = refmem[t.addr[7:0]];
                    if (pick_cpu) cpu_done_cyc = cyc + L + 1;
                    else          dma_ack_cyc  = cyc + L + 1;
                    last_dma   = !pick_cpu;
                    busy_until = cyc + L;
                    sb.push_back(t);
                end
            end
        end
    end

    // ---------------- monitor ----------------
    txn_t cur;
    bit   in_win = 1'b0;
    int   win_len = 0;

    always @(negedge CLK) begin
        if (!RST) begin
            check("reset_outputs",
                  {CpuMemOutput, CpuStall, DmaRData, DmaAck, MemRead, MemWrite, MemAddr, MemData},
                  64'h0);
            in_win = 1'b0;
        end else begin
            check("cpu_stall", CpuStall, exp_stall);
            check("dma_ack", DmaAck, exp_ack);
            if ((MemRead || MemWrite) && !in_win) begin
                check("access_expected", sb.size() > 0, 1);
                if (sb.size() > 0) begin
                    cur     = sb.pop_front();
                    in_win  = 1'b1;
                    win_len = 1;
                    check("grant_cycle", cyc, cur.start);
                    check("start_write", MemWrite, cur.we);
                    check("start_read", MemRead, !cur.we);
                    check("start_addr", MemAddr, cur.addr);
                    if (cur.we) check("start_wdata", MemData, cur.wdata);
                end
            end else if ((MemRead || MemWrite) && in_win) begin
                win_len++;
                check("hold_write", MemWrite, cur.we);
                check("hold_addr", MemAddr, cur.addr);
                if (cur.we) check("hold_wdata", MemData, cur.wdata);
            end else if (in_win) begin
                in_win = 1'b0;
                check("access_beats", win_len, L);
                if (!cur.we && cur.cpu)  check("cpu_rdata", CpuMemOutput, cur.rdata);
                if (!cur.we && !cur.cpu) check("dma_rdata", DmaRData, cur.rdata);
                grant_log.push_back(cur.cpu);
            end
        end
    end

    // ---------------- random driver ----------------
    bit cpu_active = 1'b0;
    bit dma_active = 1'b0;

    task automatic drive_cycle(input int p_cpu, input int p_dma);
        bit w;
        @(posedge CLK);
        #1;
        if (cpu_active && cyc == cpu_done_cyc + 1) cpu_active = 1'b0;
        if (!cpu_active) begin
            if (int'($urandom_range(99)) < p_cpu) begin
                cpu_active  = 1'b1;
                w           = 1'($urandom_range(1));
                CpuMemWrite = w;
                CpuMemRead  = w ? 1'($urandom_range(1)) : 1'b1;
                CpuMemAddr  = {8'($urandom), 8'($urandom_range(31))};
                CpuMemData  = 16'($urandom);
            end else begin
                CpuMemRead  = 1'b0;
                CpuMemWrite = 1'b0;
            end
        end else if (cpu_done_cyc > cyc) begin
            // In flight: command changes must be ignored, and a dropped request must not abort.
            if ($urandom_range(3) == 0) begin
                CpuMemAddr = 16'($urandom);
                CpuMemData = 16'($urandom);
            end
            if ($urandom_range(15) == 0) begin
                CpuMemRead  = 1'b0;
                CpuMemWrite = 1'b0;
            end
        end
        if (dma_active && cyc == dma_ack_cyc + 1) dma_active = 1'b0;
        if (!dma_active) begin
            if (int'($urandom_range(99)) < p_dma) begin
                dma_active = 1'b1;
                DmaReq     = 1'b1;
                DmaWe      = 1'($urandom_range(1));
                DmaAddr    = {8'($urandom), 8'($urandom_range(31))};
                DmaWData   = 16'($urandom);
            end else begin
                DmaReq  = 1'b0;
                DmaAddr = 16'($urandom);
            end
        end else if (dma_ack_cyc > cyc && $urandom_range(3) == 0) begin
            DmaAddr  = 16'($urandom);
            DmaWData = 16'($urandom);
        end
    endtask

    // ---------------- directed + random stimulus ----------------
    initial begin : stim
        int n, rd, k, wr, cpu_s, dma_s, ack_c, acks;
        logic [15:0] cpu_out;
        RST = 1'b0;
        CpuMemRead = 1'b0; CpuMemWrite = 1'b0; CpuMemAddr = '0; CpuMemData = '0;
        DmaReq = 1'b0; DmaWe = 1'b0; DmaAddr = '0; DmaWData = '0;

        // 1: reset held with the clock running; the monitor checks all outputs every cycle.
        repeat (3) @(posedge CLK);
        #1 RST = 1'b1;
        @(negedge CLK);
        check("t1_idle_after_reset", {MemRead, MemWrite, CpuStall, DmaAck}, 4'h0);

        // 2: CPU read of 0x0010.
        @(posedge CLK);
        #1 CpuMemRead = 1'b1; CpuMemAddr = 16'h0010;
        n = 0; rd = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            if (MemRead && MemAddr == 16'h0010) rd++;
            if (!CpuStall) break;
            n++;
        end
        check("t2_stall_cycles", n, 3);
        check("t2_read_beats", rd, 2);
        check("t2_read_data", CpuMemOutput, 16'h1234);
        @(posedge CLK);
        #1 CpuMemRead = 1'b0;

        // 3: DMA write 0xBEEF to 0x0040.
        @(posedge CLK);
        #1 DmaReq = 1'b1; DmaWe = 1'b1; DmaAddr = 16'h0040; DmaWData = 16'hBEEF;
        k = -1; wr = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            if (MemWrite && MemAddr == 16'h0040 && MemData == 16'hBEEF) wr++;
            if (DmaAck) begin
                k = i;
                break;
            end
        end
        check("t3_ack_latency", k, 3);
        check("t3_write_beats", wr, 2);
        @(posedge CLK);
        #1 DmaReq = 1'b0; DmaWe = 1'b0;

        // 4: CPU read and DMA read in the same cycle right after reset.
        @(posedge CLK);
        #1 RST = 1'b0;
        @(posedge CLK);
        #1 RST = 1'b1;
        @(posedge CLK);
        #1;
        CpuMemRead = 1'b1; CpuMemAddr = 16'h0040;
        DmaReq = 1'b1; DmaWe = 1'b0; DmaAddr = 16'h0010;
        cpu_s = -1; dma_s = -1; ack_c = -1; acks = 0; cpu_out = '0;
        for (int r = 0; r < 10; r++) begin
            @(negedge CLK);
            if (MemRead && MemAddr == 16'h0040 && cpu_s < 0) cpu_s = r;
            if (MemRead && MemAddr == 16'h0010 && dma_s < 0) dma_s = r;
            if (DmaAck) begin
                acks++;
                ack_c = r;
            end
            if (r == 3) cpu_out = CpuMemOutput;
            @(posedge CLK);
            #1;
            if (r == 3) CpuMemRead = 1'b0;
            if (ack_c == r) DmaReq = 1'b0;
        end
        check("t4_cpu_first_beat", cpu_s, 1);
        check("t4_dma_first_beat", dma_s, 4);
        check("t4_ack_cycle", ack_c, 6);
        check("t4_ack_count", acks, 1);
        check("t4_cpu_data", cpu_out, 16'hBEEF);
        check("t4_dma_data", DmaRData, 16'h1234);

        // 6: reset during the second beat of a DMA read, request held through reset.
        @(posedge CLK);
        #1 DmaReq = 1'b1; DmaWe = 1'b0; DmaAddr = 16'h0010;
        @(posedge CLK);
        @(posedge CLK);
        #1 RST = 1'b0;
        #1;
        check("t6_strobes_cleared", {MemRead, MemWrite, DmaAck}, 3'h0);
        check("t6_rdata_cleared", DmaRData, 16'h0);
        @(posedge CLK);
        @(posedge CLK);
        #1 RST = 1'b1;
        ack_c = -1; acks = 0; rd = 0;
        for (int r = 0; r < 8; r++) begin
            @(negedge CLK);
            if (MemRead && MemAddr == 16'h0010) rd++;
            if (DmaAck) begin
                acks++;
                if (ack_c < 0) ack_c = r;
            end
            @(posedge CLK);
            #1;
            if (ack_c == r) DmaReq = 1'b0;
        end
        check("t6_restart_ack", ack_c, 3);
        check("t6_ack_count", acks, 1);
        check("t6_restart_beats", rd, 2);
        check("t6_dma_data", DmaRData, 16'h1234);

        // 5: both sides requesting continuously -> strict alternation, CPU first.
        grant_log.delete();
        for (int i = 0; i < 40; i++) drive_cycle(100, 100);
        check("t5_transfers", grant_log.size() >= 6, 1);
        if (grant_log.size() >= 6)
            for (int i = 0; i < 6; i++) check("t5_alternate", grant_log[i], (i % 2) == 0);

        // Random traffic, then drain.
        for (int i = 0; i < 1500; i++) drive_cycle(40, 40);
        for (int i = 0; i < 30; i++) drive_cycle(0, 0);
        check("drain_scoreboard", sb.size(), 0);
        check("drain_window", in_win, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
